// File: rtl/mem_access_pkg.sv
// Shared types and encodings for the memory-access stage: FSM states,
// funct3 access sizes and fault cause codes.
package mem_access_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } mem_state_t;

  localparam logic [2:0] SIZE_B  = 3'b000;
  localparam logic [2:0] SIZE_H  = 3'b001;
  localparam logic [2:0] SIZE_W  = 3'b010;
  localparam logic [2:0] SIZE_BU = 3'b100;
  localparam logic [2:0] SIZE_HU = 3'b101;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_ILLEGAL  = 2'b10;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b11;

  function automatic logic size_legal(input logic [2:0] size);
    return (size == SIZE_B) || (size == SIZE_H) || (size == SIZE_W) ||
           (size == SIZE_BU) || (size == SIZE_HU);
  endfunction

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic misaligned(input logic [2:0] size, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    if (size[1:0] == 2'b01) bad = off[0];
    if (size[1:0] == 2'b10) bad = (off != 2'b00);
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Load alignment: moves the addressed byte/halfword of the read word down to
// bit 0 and applies sign or zero extension according to funct3.
module mem_load_align
  import mem_access_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  byte_off,
  input  logic [31:0] rdata,
  output logic [31:0] load_v
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {byte_off, 3'b000};
    case (size)
      SIZE_B:  load_v = {{24{shifted[7]}}, shifted[7:0]};
      SIZE_BU: load_v = {24'h000000, shifted[7:0]};
      SIZE_H:  load_v = {{16{shifted[15]}}, shifted[15:0]};
      SIZE_HU: load_v = {16'h0000, shifted[15:0]};
      default: load_v = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: turns a latched load/store request into a single
// valid/ready bus transaction and reports completion, load data and faults.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] store_v,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_we,
  output logic [31:0] req_addr,
  output logic [3:0]  req_wstrb,
  output logic [31:0] req_wdata,
  input  logic        resp_valid,
  input  logic [31:0] resp_rdata,
  output logic        done,
  output logic [31:0] load_v,
  output logic        fault,
  output logic [1:0]  fault_cause
);

  localparam bit         TIMEOUT_EN = (WAIT_LIMIT != 0);
  localparam logic [7:0] LAST_CNT   = TIMEOUT_EN ? 8'(WAIT_LIMIT - 1) : 8'hFF;

  mem_state_t  state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] store_q, store_d;
  logic [1:0]  cause_q, cause_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] load_v_q, load_v_d;
  logic [31:0] aligned_v;
  logic [7:0]  cnt_sat;
  logic        timeout_hit;

  mem_load_align u_load_align (
    .size     (size_q),
    .byte_off (addr_q[1:0]),
    .rdata    (resp_rdata),
    .load_v   (aligned_v)
  );

  assign cnt_sat     = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  assign timeout_hit = TIMEOUT_EN && (cnt_q == LAST_CNT);

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    size_d   = size_q;
    addr_d   = addr_q;
    store_d  = store_q;
    cause_d  = cause_q;
    cnt_d    = cnt_q;
    load_v_d = load_v_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          we_d    = mem_write;
          size_d  = size;
          addr_d  = addr;
          store_d = store_v;
          cause_d = FAULT_NONE;
          if (!mem_read && !mem_write) begin
            state_d = ST_DONE;
          end else if ((mem_read && mem_write) || !size_legal(size)) begin
            cause_d = FAULT_ILLEGAL;
            state_d = ST_DONE;
          end else if (misaligned(size, addr[1:0])) begin
            cause_d = FAULT_MISALIGN;
            state_d = ST_DONE;
          end else begin
            cnt_d   = 8'd0;
            state_d = ST_REQ;
          end
        end
      end
      // An accepted request wins over a timeout in the same cycle so the
      // responder's ack is still awaited.
      ST_REQ: begin
        cnt_d = cnt_sat;
        if (req_ready) begin
          state_d = ST_WAIT;
        end else if (timeout_hit) begin
          cause_d = FAULT_TIMEOUT;
          state_d = ST_DONE;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_sat;
        if (resp_valid) begin
          if (!we_q) load_v_d = aligned_v;
          state_d = ST_DONE;
        end else if (timeout_hit) begin
          cause_d = FAULT_TIMEOUT;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      size_q   <= 3'b000;
      addr_q   <= 32'h0;
      store_q  <= 32'h0;
      cause_q  <= FAULT_NONE;
      cnt_q    <= 8'd0;
      load_v_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      store_q  <= store_d;
      cause_q  <= cause_d;
      cnt_q    <= cnt_d;
      load_v_q <= load_v_d;
    end
  end

  always_comb begin
    req_valid = (state_q == ST_REQ);
    req_we    = req_valid && we_q;
    req_addr  = {addr_q[31:2], 2'b00};
    req_wstrb = 4'b0000;
    case (size_q[1:0])
      2'b00:   req_wdata = {4{store_q[7:0]}};
      2'b01:   req_wdata = {2{store_q[15:0]}};
      default: req_wdata = store_q;
    endcase
    if (req_we) begin
      case (size_q[1:0])
        2'b00:   req_wstrb = 4'b0001 << addr_q[1:0];
        2'b01:   req_wstrb = 4'b0011 << addr_q[1:0];
        default: req_wstrb = 4'b1111;
      endcase
    end
    done        = (state_q == ST_DONE);
    fault       = done && (cause_q != FAULT_NONE);
    fault_cause = done ? cause_q : FAULT_NONE;
    load_v      = load_v_q;
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access (WAIT_LIMIT = 8): loads with
// extension, store strobes/payload stability, faults, timeout and reset abort.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  size;
  logic [31:0] addr;
  logic [31:0] store_v;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_wstrb;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        done;
  logic [31:0] load_v;
  logic        fault;
  logic [1:0]  fault_cause;

  int total = 0;
  int bad   = 0;

  mem_access #(.WAIT_LIMIT(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .size        (size),
    .addr        (addr),
    .store_v     (store_v),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wstrb   (req_wstrb),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .done        (done),
    .load_v      (load_v),
    .fault       (fault),
    .fault_cause (fault_cause)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic rd, input logic wr, input logic [2:0] sz,
                               input logic [31:0] a, input logic [31:0] sv);
    start     = st;
    mem_read  = rd;
    mem_write = wr;
    size      = sz;
    addr      = a;
    store_v   = sv;
  endtask

  // Load with ready in the first REQ cycle and the response in the first WAIT cycle;
  // afterwards the DUT sits in DONE.
  task automatic runLoad(input string tag, input logic [2:0] sz, input logic [31:0] a,
                         input logic [31:0] rd, input logic [31:0] exp_v);
    applyStimulus(1'b1, 1'b1, 1'b0, sz, a, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    req_ready = 1'b1;
    checkOutput({tag, "_req_addr"}, req_addr, {a[31:2], 2'b00});
    tick();
    req_ready  = 1'b0;
    resp_valid = 1'b1;
    resp_rdata = rd;
    tick();
    resp_valid = 1'b0;
    checkOutput({tag, "_done"}, {31'h0, done}, 32'd1);
    checkOutput({tag, "_load_v"}, load_v, exp_v);
    checkOutput({tag, "_fault"}, {31'h0, fault}, 32'd0);
    tick();
  endtask

  // Access rejected in IDLE: expect DONE right after the start edge with no bus request.
  task automatic runReject(input string tag, input logic rd, input logic wr, input logic [2:0] sz,
                           input logic [31:0] a, input logic [1:0] exp_cause);
    applyStimulus(1'b1, rd, wr, sz, a, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    checkOutput({tag, "_req_valid"}, {31'h0, req_valid}, 32'd0);
    checkOutput({tag, "_done"}, {31'h0, done}, 32'd1);
    checkOutput({tag, "_fault"}, {31'h0, fault}, {31'h0, exp_cause != 2'b00});
    checkOutput({tag, "_cause"}, {30'h0, fault_cause}, {30'h0, exp_cause});
    tick();
    checkOutput({tag, "_done_clear"}, {31'h0, done}, 32'd0);
  endtask

  initial begin
    int req_cycles;
    int waited;
    logic seen_done;

    rst        = 1'b1;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = 32'h0;
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    checkOutput("rst_req_valid", {31'h0, req_valid}, 32'd0);
    checkOutput("rst_req_we", {31'h0, req_we}, 32'd0);
    checkOutput("rst_wstrb", {28'h0, req_wstrb}, 32'd0);
    checkOutput("rst_done", {31'h0, done}, 32'd0);
    checkOutput("rst_fault", {31'h0, fault}, 32'd0);
    checkOutput("rst_cause", {30'h0, fault_cause}, 32'd0);
    checkOutput("rst_load_v", load_v, 32'h0);

    // lw 0x100: ready in the first REQ cycle, response three cycles after acceptance.
    applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0);
    req_ready = 1'b1;
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    checkOutput("lw_req_valid", {31'h0, req_valid}, 32'd1);
    checkOutput("lw_req_we", {31'h0, req_we}, 32'd0);
    checkOutput("lw_req_addr", req_addr, 32'h0000_0100);
    checkOutput("lw_wstrb", {28'h0, req_wstrb}, 32'd0);
    tick();
    req_ready = 1'b0;
    checkOutput("lw_valid_drop", {31'h0, req_valid}, 32'd0);
    tick();
    tick();
    resp_valid = 1'b1;
    resp_rdata = 32'hDEAD_BEEF;
    checkOutput("lw_no_early_done", {31'h0, done}, 32'd0);
    tick();
    resp_valid = 1'b0;
    checkOutput("lw_done", {31'h0, done}, 32'd1);
    checkOutput("lw_load_v", load_v, 32'hDEAD_BEEF);
    checkOutput("lw_fault", {31'h0, fault}, 32'd0);
    tick();
    checkOutput("lw_done_once", {31'h0, done}, 32'd0);
    checkOutput("lw_load_held", load_v, 32'hDEAD_BEEF);

    runLoad("lb", 3'b000, 32'h0000_0103, 32'h80FF_FF7F, 32'hFFFF_FF80);
    runLoad("lbu", 3'b100, 32'h0000_0103, 32'h80FF_FF7F, 32'h0000_0080);
    runLoad("lhu", 3'b101, 32'h0000_0102, 32'h80FF_FF7F, 32'h0000_80FF);
    runLoad("lh", 3'b001, 32'h0000_0102, 32'h80FF_FF7F, 32'hFFFF_80FF);
    runLoad("lb0", 3'b000, 32'h0000_0200, 32'h1234_5678, 32'h0000_0078);

    // sh 0x206 with ready held low five cycles; inputs change after start to prove latching.
    applyStimulus(1'b1, 1'b0, 1'b1, 3'b001, 32'h0000_0206, 32'h1234_ABCD);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 3'b010, 32'h0000_0F00, 32'h5555_5555);
    for (int i = 0; i < 5; i++) begin
      checkOutput("sh_valid", {31'h0, req_valid}, 32'd1);
      checkOutput("sh_we", {31'h0, req_we}, 32'd1);
      checkOutput("sh_addr", req_addr, 32'h0000_0204);
      checkOutput("sh_wstrb", {28'h0, req_wstrb}, 32'h0000_000C);
      checkOutput("sh_wdata", req_wdata, 32'hABCD_ABCD);
      tick();
    end
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    checkOutput("sh_valid_drop", {31'h0, req_valid}, 32'd0);
    resp_valid = 1'b1;
    tick();
    resp_valid = 1'b0;
    checkOutput("sh_done", {31'h0, done}, 32'd1);
    checkOutput("sh_fault", {31'h0, fault}, 32'd0);
    checkOutput("sh_load_kept", load_v, 32'h0000_0078);
    tick();

    // sb 0x301: single lane strobe and byte replication.
    applyStimulus(1'b1, 1'b0, 1'b1, 3'b000, 32'h0000_0301, 32'hFFFF_FFA5);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    checkOutput("sb_wstrb", {28'h0, req_wstrb}, 32'h0000_0002);
    checkOutput("sb_wdata", req_wdata, 32'hA5A5_A5A5);
    req_ready = 1'b1;
    tick();
    req_ready  = 1'b0;
    resp_valid = 1'b1;
    tick();
    resp_valid = 1'b0;
    checkOutput("sb_done", {31'h0, done}, 32'd1);
    tick();

    runReject("lw_mis", 1'b1, 1'b0, 3'b010, 32'h0000_0101, 2'b01);
    runReject("lh_mis", 1'b1, 1'b0, 3'b001, 32'h0000_0103, 2'b01);
    runReject("rw_both", 1'b1, 1'b1, 3'b010, 32'h0000_0100, 2'b10);
    runReject("bad_size", 1'b1, 1'b0, 3'b011, 32'h0000_0100, 2'b10);
    runReject("noop", 1'b0, 1'b0, 3'b010, 32'h0000_0101, 2'b00);
    checkOutput("noop_load_kept", load_v, 32'h0000_0078);

    // A start presented during DONE must not launch a request.
    applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'h0);
    checkOutput("start_in_done", {31'h0, done}, 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    checkOutput("start_in_done_ignored", {31'h0, req_valid}, 32'd0);
    tick();
    checkOutput("still_idle", {31'h0, req_valid | done}, 32'd0);

    // Timeout: ready never asserted, limit 8 means eight REQ cycles.
    applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    req_cycles = 0;
    waited     = 0;
    seen_done  = 1'b0;
    while (!seen_done && waited < 40) begin
      if (done) seen_done = 1'b1;
      else begin
        if (req_valid) req_cycles++;
        tick();
        waited++;
      end
    end
    checkOutput("to_done_seen", {31'h0, seen_done}, 32'd1);
    checkOutput("to_req_cycles", req_cycles, 32'd8);
    checkOutput("to_req_dropped", {31'h0, req_valid}, 32'd0);
    checkOutput("to_fault", {31'h0, fault}, 32'd1);
    checkOutput("to_cause", {30'h0, fault_cause}, 32'd3);
    tick();
    resp_valid = 1'b1;
    resp_rdata = 32'hBAD0_BAD0;
    tick();
    resp_valid = 1'b0;
    checkOutput("to_stale_resp", {31'h0, done}, 32'd0);
    checkOutput("to_stale_load", load_v, 32'h0000_0078);

    // Reset while in WAIT, then a stale response.
    applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0600, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rstw_req_valid", {31'h0, req_valid}, 32'd0);
    checkOutput("rstw_done", {31'h0, done}, 32'd0);
    resp_valid = 1'b1;
    resp_rdata = 32'hCAFE_F00D;
    tick();
    resp_valid = 1'b0;
    checkOutput("rstw_stale_done", {31'h0, done}, 32'd0);
    checkOutput("rstw_load_v", load_v, 32'h0);
    tick();
    checkOutput("rstw_idle", {31'h0, req_valid | done}, 32'd0);
    runLoad("lw_after_rst", 3'b010, 32'h0000_0700, 32'h1122_3344, 32'h1122_3344);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
